// File: rtl/md_fifo_pkg.sv
// Shared width helpers for the merge FIFO and its per-channel buffers.
package md_fifo_pkg;

    // Ceiling log2; clog2(1) = 0.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    // Channel index width, never narrower than one bit.
    function automatic int ch_w(input int num_ch);
        return (clog2(num_ch) > 1) ? clog2(num_ch) : 1;
    endfunction

    // Derived widths for the default configuration (depth 8, 4 channels).
    localparam int CNT_W = cnt_w(8);
    localparam int CH_W  = ch_w(4);

endpackage

// File: rtl/fifo_channel.sv
// Single-channel circular buffer. wr/rd arrive already qualified by the
// parent, so this block never sees a write when full or a read when empty.
module fifo_channel
    import md_fifo_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic                    rd,
    output logic [WIDTH-1:0]        rdata,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic                    full
);

    localparam int PTR_BITS = clog2(DEPTH);
    localparam int CNT_BITS = cnt_w(DEPTH);

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [PTR_BITS-1:0] head_q, head_d;
    logic [PTR_BITS-1:0] tail_q, tail_d;
    logic [CNT_BITS-1:0] count_q, count_d;

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (wr) tail_d = tail_q + PTR_BITS'(1);
        if (rd) head_d = head_q + PTR_BITS'(1);
        if (wr && !rd) begin
            count_d = count_q + CNT_BITS'(1);
        end else if (!wr && rd) begin
            count_d = count_q - CNT_BITS'(1);
        end
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; stale entries are never presented.
    always_ff @(posedge clk) begin
        if (wr) mem_q[tail_q] <= wdata;
    end

    // Head word and status straight from registered state.
    always_comb begin
        rdata = mem_q[head_q];
        count = count_q;
        full  = (count_q == CNT_BITS'(DEPTH));
    end

endmodule

// File: rtl/merge_fifo.sv
// Multi-channel FIFO merging NUM_CH independent queues onto one
// first-word-fall-through output with round-robin arbitration.
module merge_fifo
    import md_fifo_pkg::*;
#(
    parameter int FIFO_WIDTH = 64,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_CH     = 4,
    parameter int AF_THRESH  = FIFO_DEPTH - 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_CH*FIFO_WIDTH-1:0]         in,
    input  logic [NUM_CH-1:0]                    produce,
    output logic [NUM_CH-1:0]                    full,
    output logic [NUM_CH-1:0]                    almost_full,
    output logic [FIFO_WIDTH-1:0]                out,
    output logic [ch_w(NUM_CH)-1:0]              out_ch,
    output logic                                 out_valid,
    input  logic                                 consume,
    output logic [NUM_CH*cnt_w(FIFO_DEPTH)-1:0]  util,
    output logic [NUM_CH-1:0]                    overflow
);

    localparam int CNT_BITS = cnt_w(FIFO_DEPTH);
    localparam int CH_BITS  = ch_w(NUM_CH);

    logic [FIFO_WIDTH-1:0] rdata [NUM_CH];
    logic [CNT_BITS-1:0]   count [NUM_CH];
    logic [NUM_CH-1:0]     ch_full;
    logic [NUM_CH-1:0]     ch_wr;
    logic [NUM_CH-1:0]     ch_rd;
    logic [NUM_CH-1:0]     nonempty;
    logic [CH_BITS-1:0]    rr_q, rr_d;
    logic [CH_BITS-1:0]    gnt_ch;
    logic                  gnt_valid;
    logic [NUM_CH-1:0]     overflow_q, overflow_d;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        fifo_channel #(
            .WIDTH (FIFO_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .wr    (ch_wr[c]),
            .wdata (in[c*FIFO_WIDTH +: FIFO_WIDTH]),
            .rd    (ch_rd[c]),
            .rdata (rdata[c]),
            .count (count[c]),
            .full  (ch_full[c])
        );
    end

    // Round-robin search: first non-empty channel at or after rr_q, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        gnt_valid = 1'b0;
        gnt_ch    = '0;
        nonempty  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            nonempty[c] = (count[c] != '0);
        end
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(rr_q) + i) % NUM_CH;
            if (!gnt_valid && nonempty[idx]) begin
                gnt_valid = 1'b1;
                gnt_ch    = CH_BITS'(idx);
            end
        end
    end

    // Pop/push qualification, sticky overflow, status outputs and pointer advance.
    always_comb begin
        ch_rd       = '0;
        ch_wr       = '0;
        overflow_d  = overflow_q;
        full        = '0;
        almost_full = '0;
        util        = '0;
        rr_d        = rr_q;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_rd[c]       = consume && gnt_valid && (gnt_ch == CH_BITS'(c));
            // A pop on a full channel frees the slot for a same-cycle write.
            ch_wr[c]       = produce[c] && (!ch_full[c] || ch_rd[c]);
            overflow_d[c]  = overflow_q[c] | (produce[c] & ch_full[c] & ~ch_rd[c]);
            full[c]        = ch_full[c];
            almost_full[c] = (int'(count[c]) >= AF_THRESH);
            util[c*CNT_BITS +: CNT_BITS] = count[c];
        end
        if (consume && gnt_valid) begin
            rr_d = (gnt_ch == CH_BITS'(NUM_CH - 1)) ? '0 : gnt_ch + CH_BITS'(1);
        end
    end

    // Arbiter pointer and overflow flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q       <= '0;
            overflow_q <= '0;
        end else begin
            rr_q       <= rr_d;
            overflow_q <= overflow_d;
        end
    end

    // Output word is forced to zero whenever nothing is granted.
    always_comb begin
        out_valid = gnt_valid;
        out_ch    = gnt_ch;
        out       = gnt_valid ? rdata[gnt_ch] : '0;
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_merge_fifo.sv
// Bench for merge_fifo: queue-based reference model plus directed scenarios.
module tb_merge_fifo;

    localparam int W  = 64;
    localparam int D  = 8;
    localparam int N  = 4;
    localparam int AF = D - 2;
    localparam int CW = 4;
    localparam int HW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N*W-1:0]  in_bus;
    logic [N-1:0]    produce;
    logic [N-1:0]    full;
    logic [N-1:0]    almost_full;
    logic [W-1:0]    out;
    logic [HW-1:0]   out_ch;
    logic            out_valid;
    logic            consume;
    logic [N*CW-1:0] util;
    logic [N-1:0]    overflow;

    always #5 clk = ~clk;

    merge_fifo #(
        .FIFO_WIDTH (W),
        .FIFO_DEPTH (D),
        .NUM_CH     (N),
        .AF_THRESH  (AF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (in_bus),
        .produce     (produce),
        .full        (full),
        .almost_full (almost_full),
        .out         (out),
        .out_ch      (out_ch),
        .out_valid   (out_valid),
        .consume     (consume),
        .util        (util),
        .overflow    (overflow)
    );

    // Reference model: one queue per channel, a round-robin start index, sticky flags.
    logic [W-1:0] mq [N][$];
    int           m_rr = 0;
    logic [N-1:0] m_ovf = '0;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int cmp_g;
    logic [W-1:0] cmp_out;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant();
        int idx;
        for (int i = 0; i < N; i++) begin
            idx = (m_rr + i) % N;
            if (mq[idx].size() > 0) return idx;
        end
        return -1;
    endfunction

    task automatic model_step();
        int g;
        bit popv;
        logic [N-1:0] fullv;
        if (rst) begin
            for (int c = 0; c < N; c++) mq[c].delete();
            m_rr  = 0;
            m_ovf = '0;
            return;
        end
        g = m_grant();
        popv = consume && (g >= 0);
        for (int c = 0; c < N; c++) fullv[c] = (mq[c].size() == D);
        if (popv) begin
            void'(mq[g].pop_front());
            m_rr = (g + 1) % N;
        end
        for (int c = 0; c < N; c++) begin
            if (produce[c]) begin
                if (!fullv[c] || (popv && g == c)) mq[c].push_back(in_bus[c*W +: W]);
                else m_ovf[c] = 1'b1;
            end
        end
    endtask

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            cmp_g = m_grant();
            check("out_valid", 64'(out_valid), 64'(cmp_g >= 0));
            if (cmp_g >= 0) begin
                check("out_ch", 64'(out_ch), 64'(cmp_g));
                cmp_out = mq[cmp_g][0];
            end else begin
                cmp_out = '0;
            end
            check("out", out, cmp_out);
            for (int c = 0; c < N; c++) begin
                check($sformatf("full%0d", c), 64'(full[c]), 64'(mq[c].size() == D));
                check($sformatf("almost_full%0d", c), 64'(almost_full[c]), 64'(mq[c].size() >= AF));
                check($sformatf("util%0d", c), 64'(util[c*CW +: CW]), 64'(mq[c].size()));
                check($sformatf("overflow%0d", c), 64'(overflow[c]), 64'(m_ovf[c]));
            end
        end
    end

    task automatic put(input int c, input logic [W-1:0] v);
        in_bus[c*W +: W] = v;
    endtask

    task automatic cyc(input logic [N-1:0] p, input logic c, input logic r);
        produce = p;
        consume = c;
        rst     = r;
        @(posedge clk);
        model_step();
        #1;
    endtask

    logic [N-1:0] rp;
    logic         rc;
    logic         rr_bit;

    initial begin
        rst     = 1'b1;
        produce = '0;
        consume = 1'b0;
        in_bus  = '0;
        cyc('0, 1'b0, 1'b1);
        cyc('0, 1'b0, 1'b1);

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out", out, 64'd0);
        check("rst_out_ch", 64'(out_ch), 64'd0);
        check("rst_util", 64'(util), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_ovf", 64'(overflow), 64'd0);
        chk_en = 1'b1;

        // Single write on ch2 appears the following cycle.
        put(2, 64'hA5);
        cyc(4'b0100, 1'b0, 1'b0);
        check("a5_valid", 64'(out_valid), 64'd1);
        check("a5_ch", 64'(out_ch), 64'd2);
        check("a5_out", out, 64'hA5);
        check("a5_util2", 64'(util[2*CW +: CW]), 64'd1);
        cyc('0, 1'b1, 1'b0);

        // One word per channel drained in index order.
        cyc('0, 1'b0, 1'b1);
        for (int c = 0; c < N; c++) put(c, 64'(c * 16 + 1));
        cyc(4'hF, 1'b0, 1'b0);
        for (int k = 0; k < N; k++) begin
            check("rr_seq", 64'(out_ch), 64'(k));
            cyc('0, 1'b1, 1'b0);
        end
        check("rr_empty", 64'(out_valid), 64'd0);

        // Fill ch1, then a dropped 9th write.
        cyc('0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) begin
            put(1, 64'(100 + i));
            cyc(4'b0010, 1'b0, 1'b0);
        end
        put(1, 64'hDEAD);
        cyc(4'b0010, 1'b0, 1'b0);
        check("ovf_full1", 64'(full[1]), 64'd1);
        check("ovf_flag1", 64'(overflow[1]), 64'd1);
        check("ovf_util1", 64'(util[CW +: CW]), 64'd8);
        for (int i = 0; i < D; i++) begin
            check("ovf_drain", out, 64'(100 + i));
            cyc('0, 1'b1, 1'b0);
        end
        check("ovf_empty", 64'(out_valid), 64'd0);
        check("ovf_sticky", 64'(overflow[1]), 64'd1);

        // Full ch0 with simultaneous pop and push.
        cyc('0, 1'b0, 1'b1);
        for (int i = 0; i < D; i++) begin
            put(0, 64'(200 + i));
            cyc(4'b0001, 1'b0, 1'b0);
        end
        put(0, 64'h77);
        cyc(4'b0001, 1'b1, 1'b0);
        check("pp_util0", 64'(util[0 +: CW]), 64'd8);
        check("pp_ovf0", 64'(overflow[0]), 64'd0);
        check("pp_head", out, 64'(201));

        // Almost-full threshold on ch0.
        cyc('0, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            put(0, 64'(300 + i));
            cyc(4'b0001, 1'b0, 1'b0);
        end
        check("af_set", 64'(almost_full[0]), 64'd1);
        cyc('0, 1'b1, 1'b0);
        check("af_clr", 64'(almost_full[0]), 64'd0);

        // Reset in the middle of traffic, with an overflow already flagged.
        cyc('0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            put(3, 64'(400 + i));
            cyc(4'b1000, 1'b0, 1'b0);
        end
        for (int i = 0; i < D + 1; i++) begin
            put(0, 64'(500 + i));
            cyc(4'b0001, 1'b0, 1'b0);
        end
        check("mr_pre_ovf", 64'(overflow[0]), 64'd1);
        cyc('0, 1'b1, 1'b0);
        cyc(4'hF, 1'b1, 1'b1);
        check("mr_valid", 64'(out_valid), 64'd0);
        check("mr_util", 64'(util), 64'd0);
        check("mr_ovf", 64'(overflow), 64'd0);

        // Randomized traffic in three load phases.
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < N; c++) put(c, {$urandom, $urandom});
            rp = N'($urandom);
            if (k < 1000)      rc = ($urandom_range(0, 3) == 0);
            else if (k < 2000) rc = ($urandom_range(0, 3) != 0);
            else               rc = 1'($urandom_range(0, 1));
            rr_bit = ($urandom_range(0, 499) == 0);
            cyc(rp, rc, rr_bit);
        end

        produce = '0;
        consume = 1'b0;
        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
